// File: rtl/move_counter_bcd_pkg.sv
// Shared types and constants for the Lights Out move counter.
// Holds the BCD digit type, display constants and a BCD magnitude compare.
package move_counter_bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX    = 4'd9;
    localparam logic [6:0] BLANK_SEG  = 7'h7F;
    localparam int         MAX_DIGITS = 6;

    // Less-than over packed BCD, most significant digit decides first.
    // Callers zero-extend narrower counts to MAX_DIGITS digits.
    function automatic logic bcd_less(input logic [4*MAX_DIGITS-1:0] a,
                                      input logic [4*MAX_DIGITS-1:0] b);
        logic decided;
        logic lt;
        decided = 1'b0;
        lt      = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                decided = 1'b1;
                lt      = (a[4*i +: 4] < b[4*i +: 4]);
            end
        end
        return lt;
    endfunction

endpackage

// File: rtl/move_counter_bcd_if.sv
// Signal bundle between the game logic and the move counter.
// There is no valid/ready handshake here: inputs are plain levels sampled
// on every clock edge, and every output is valid on every cycle.
interface move_counter_bcd_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    move_in;
    logic                    clear;
    logic                    solved;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    max_reached;
    logic [4*NUM_DIGITS-1:0] best_digits;
    logic                    best_valid;

    // Game-side view: drives the levels, consumes the display data.
    modport master (
        output move_in, clear, solved,
        input  digits, blank, max_reached, best_digits, best_valid
    );

    // Counter-side view.
    modport slave (
        input  move_in, clear, solved,
        output digits, blank, max_reached, best_digits, best_valid
    );
endinterface

// File: rtl/move_counter_bcd_decade.sv
// One BCD decade (0..9) of the move counter, chained through carry_out.
module bcd_decade
    import move_counter_bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en_in,
    output bcd_digit_t digit,
    output logic       carry_out
);

    // Carry fires on the same cycle this decade rolls over from 9 to 0.
    assign carry_out = en_in & (digit == BCD_MAX);

    // Decade register: reset and clear both zero it, otherwise step on enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (en_in) begin
            digit <= (digit == BCD_MAX) ? bcd_digit_t'(0) : bcd_digit_t'(digit + 4'd1);
        end
    end

endmodule

// File: rtl/move_counter_bcd.sv
// Lights Out move counter with packed BCD output for the 7-segment decoders.
// Counts rising edges of move_in, freezes while solved, clears on clear.
// Optional macro BEST_SCORE_EN keeps the lowest solved count in best_digits;
// without it best_digits/best_valid are tied to zero.
module move_counter_bcd
    import move_counter_bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter bit SATURATE   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    move_counter_bcd_if.slave bus
);

    logic                    move_q;
    logic                    inc;
    logic                    all_nines;
    logic                    wrapped_q;
    logic [NUM_DIGITS:0]     carry;
    bcd_digit_t              digit_q [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] count_vec;
    logic [NUM_DIGITS-1:0]   blank_c;

    // Previous move_in level; resets high so a held move_in is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            move_q <= 1'b1;
        end else begin
            move_q <= bus.move_in;
        end
    end

    assign inc = bus.move_in & ~move_q & ~bus.solved;

    // Detect the all-9s count used for saturation and max_reached.
    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            all_nines = all_nines & (digit_q[i] == BCD_MAX);
        end
    end

    // In saturating mode the chain is never enabled once the count is all 9s.
    assign carry[0] = inc & ~(SATURATE && all_nines);

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_decade
            bcd_decade u_decade (
                .clk       (clk),
                .reset     (reset),
                .clr       (bus.clear),
                .en_in     (carry[g]),
                .digit     (digit_q[g]),
                .carry_out (carry[g+1])
            );
            assign count_vec[4*g +: 4] = digit_q[g];
        end
    endgenerate

    // Sticky wrap flag; only reachable when the chain may roll past all 9s.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrapped_q <= 1'b0;
        end else if (bus.clear) begin
            wrapped_q <= 1'b0;
        end else if (carry[NUM_DIGITS]) begin
            wrapped_q <= 1'b1;
        end
    end

    // Leading-zero mask: a digit is dark when it and everything above it is 0.
    always_comb begin
        logic zero_above;
        blank_c    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (digit_q[i] == 4'd0);
            blank_c[i] = zero_above;
        end
    end

    assign bus.digits      = count_vec;
    assign bus.blank       = blank_c;
    assign bus.max_reached = SATURATE ? all_nines : wrapped_q;

`ifdef BEST_SCORE_EN
    logic                    solved_q;
    logic [4*NUM_DIGITS-1:0] best_q;
    logic                    best_valid_q;
    logic [4*MAX_DIGITS-1:0] cur_ext;
    logic [4*MAX_DIGITS-1:0] best_ext;
    logic                    record;

    // Widen both operands so the shared compare works for any digit count.
    always_comb begin
        cur_ext                     = '0;
        best_ext                    = '0;
        cur_ext[4*NUM_DIGITS-1:0]   = count_vec;
        best_ext[4*NUM_DIGITS-1:0]  = best_q;
    end

    // A wrapped count is not a real score, so it is never recorded.
    assign record = bus.solved & ~solved_q
                  & (~best_valid_q | bcd_less(cur_ext, best_ext))
                  & (SATURATE || !wrapped_q);

    // Best-score registers; clear deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            solved_q     <= 1'b0;
            best_q       <= '0;
            best_valid_q <= 1'b0;
        end else begin
            solved_q <= bus.solved;
            if (record) begin
                best_q       <= count_vec;
                best_valid_q <= 1'b1;
            end
        end
    end

    assign bus.best_digits = best_q;
    assign bus.best_valid  = best_valid_q;
`else
    assign bus.best_digits = '0;
    assign bus.best_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_move_counter_bcd.sv
// Self-checking bench for move_counter_bcd: a saturating and a wrapping
// instance run side by side against an integer-count reference model.
module tb_move_counter_bcd;

    localparam int N    = 4;
    localparam int MAXV = 9999;

    logic clk;
    logic reset;

    move_counter_bcd_if #(.NUM_DIGITS(N)) if_sat ();
    move_counter_bcd_if #(.NUM_DIGITS(N)) if_wrap ();

    move_counter_bcd #(.NUM_DIGITS(N), .SATURATE(1'b1)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (if_sat)
    );

    move_counter_bcd #(.NUM_DIGITS(N), .SATURATE(1'b0)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (if_wrap)
    );

    // Clock and initial reset level.
    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: expected saturating-instance digits, one entry per edge.
    logic [31:0] exp_q[$];

    // Reference model state, kept as plain integers.
    bit m_move_q   = 1'b1;
    bit m_solved_q = 1'b0;
    int cnt_s      = 0;
    int cnt_w      = 0;
    bit wrapped    = 1'b0;
    int best_s     = 0;
    bit bv_s       = 1'b0;
    int best_w     = 0;
    bit bv_w       = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_blank(input int v);
        logic [31:0] b;
        int lim;
        b   = '0;
        lim = 1;
        for (int i = 1; i < N; i++) begin
            lim  = lim * 10;
            b[i] = (v < lim);
        end
        return b;
    endfunction

    // Model of one clock edge given the levels present before it.
    task automatic model_step(input bit r, input bit m, input bit c, input bit s);
        bit inc;
        if (r) begin
            cnt_s = 0; cnt_w = 0; wrapped = 0;
            m_move_q = 1; m_solved_q = 0;
            best_s = 0; bv_s = 0; best_w = 0; bv_w = 0;
        end else begin
            inc = m && !m_move_q && !s;
            if (s && !m_solved_q) begin
                if (!bv_s || cnt_s < best_s) begin best_s = cnt_s; bv_s = 1; end
                if (!wrapped && (!bv_w || cnt_w < best_w)) begin best_w = cnt_w; bv_w = 1; end
            end
            if (c) begin
                cnt_s = 0; cnt_w = 0; wrapped = 0;
            end else if (inc) begin
                if (cnt_s < MAXV) cnt_s++;
                if (cnt_w == MAXV) begin cnt_w = 0; wrapped = 1; end
                else cnt_w++;
            end
            m_move_q   = m;
            m_solved_q = s;
        end
        exp_q.push_back(to_bcd(cnt_s));
    endtask

    task automatic check_outputs();
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("digits_sat",  32'(if_sat.digits), e);
        check("digits_wrap", 32'(if_wrap.digits), to_bcd(cnt_w));
        check("max_sat",     32'(if_sat.max_reached), 32'(cnt_s == MAXV));
        check("max_wrap",    32'(if_wrap.max_reached), 32'(wrapped));
        check("blank_sat",   32'(if_sat.blank), exp_blank(cnt_s));
        check("blank_wrap",  32'(if_wrap.blank), exp_blank(cnt_w));
`ifdef BEST_SCORE_EN
        check("best_sat",    32'(if_sat.best_digits), bv_s ? to_bcd(best_s) : 32'd0);
        check("bestv_sat",   32'(if_sat.best_valid), 32'(bv_s));
        check("best_wrap",   32'(if_wrap.best_digits), bv_w ? to_bcd(best_w) : 32'd0);
        check("bestv_wrap",  32'(if_wrap.best_valid), 32'(bv_w));
`else
        check("best_sat",    32'(if_sat.best_digits), 32'd0);
        check("bestv_sat",   32'(if_sat.best_valid), 32'd0);
        check("best_wrap",   32'(if_wrap.best_digits), 32'd0);
        check("bestv_wrap",  32'(if_wrap.best_valid), 32'd0);
`endif
    endtask

    // Driver: apply levels on the falling edge, check 1 ns after the rising edge.
    task automatic tick(input bit r, input bit m, input bit c, input bit s);
        @(negedge clk);
        reset          = r;
        if_sat.move_in = m;  if_wrap.move_in = m;
        if_sat.clear   = c;  if_wrap.clear   = c;
        if_sat.solved  = s;  if_wrap.solved  = s;
        model_step(r, m, c, s);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic pulses(input int n, input bit s);
        for (int i = 0; i < n; i++) begin
            tick(0, 1, 0, s);
            tick(0, 0, 0, s);
        end
    endtask

    initial begin
        bit rs;
        bit rm;
        bit rc;
        bit rsv;
        if_sat.move_in = 1'b1; if_wrap.move_in = 1'b1;
        if_sat.clear   = 1'b0; if_wrap.clear   = 1'b0;
        if_sat.solved  = 1'b0; if_wrap.solved  = 1'b0;

        // Reset with move_in held high, then release while still high.
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 0);
        check("rst_digits", 32'(if_sat.digits), 32'h0000);
        check("rst_blank",  32'(if_sat.blank), 32'b1110);
        check("rst_max",    32'(if_sat.max_reached), 32'd0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
        check("held_move", 32'(if_sat.digits), 32'h0000);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        check("first_move", 32'(if_sat.digits), 32'h0001);

        // 123 moves, then a long held move counts once.
        tick(0, 0, 1, 0);
        pulses(123, 0);
        check("cnt_123",   32'(if_sat.digits), 32'h0123);
        check("blank_123", 32'(if_sat.blank), 32'b1000);
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        check("held_once", 32'(if_sat.digits), 32'h0124);

        // Reset in mid-count behaves like clear.
        tick(1, 1, 0, 0);
        tick(0, 1, 0, 0);
        check("mid_reset", 32'(if_wrap.digits), 32'h0000);
        tick(0, 0, 0, 0);

        // Overflow: saturate vs wrap, sticky max until clear.
        pulses(MAXV, 0);
        check("at_9999_sat",  32'(if_sat.digits), 32'h9999);
        check("at_9999_wrap", 32'(if_wrap.digits), 32'h9999);
        pulses(1, 0);
        check("ovf_sat",      32'(if_sat.digits), 32'h9999);
        check("ovf_sat_max",  32'(if_sat.max_reached), 32'd1);
        check("ovf_wrap",     32'(if_wrap.digits), 32'h0000);
        check("ovf_wrap_max", 32'(if_wrap.max_reached), 32'd1);
        pulses(2, 0);
        check("sticky_max", 32'(if_wrap.max_reached), 32'd1);
        tick(0, 0, 1, 0);
        check("clr_max", 32'(if_wrap.max_reached), 32'd0);

        // Clear coincident with a move edge drops the edge.
        pulses(19, 0);
        check("cnt_19", 32'(if_sat.digits), 32'h0019);
        tick(0, 1, 1, 0);
        check("clr_move", 32'(if_sat.digits), 32'h0000);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        check("after_clr", 32'(if_sat.digits), 32'h0001);
        tick(0, 0, 0, 0);

        // Solved freezes the count; best-score sequence.
        tick(0, 0, 1, 0);
        pulses(42, 0);
        tick(0, 0, 0, 1);
        pulses(5, 1);
        check("solved_hold", 32'(if_sat.digits), 32'h0042);
`ifdef BEST_SCORE_EN
        check("best_42",  32'(if_sat.best_digits), 32'h0042);
        check("bestv_42", 32'(if_sat.best_valid), 32'd1);
`endif
        tick(0, 0, 1, 0);
        pulses(57, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
`ifdef BEST_SCORE_EN
        check("best_57", 32'(if_sat.best_digits), 32'h0042);
`endif
        tick(0, 0, 1, 0);
        pulses(31, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
`ifdef BEST_SCORE_EN
        check("best_31", 32'(if_sat.best_digits), 32'h0031);
`endif

        // Randomized traffic against the model.
        rsv = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rs = ($urandom_range(0, 499) == 0);
            rm = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 19) == 0) rsv = ~rsv;
            tick(rs, rm, rc, rsv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/move_counter_bcd.md
Name: move_counter_bcd

Overview:
Counts player moves in the Lights Out game and presents the count as packed BCD digits, one 4-bit digit per seven-segment display. It sits directly upstream of the per-digit hex-to-seven-segment decoders. Each digit output drives one decoder input. A per-digit blank mask lets the top level force leading-zero displays dark (all segments 7'h7F).

Parameters:
NUM_DIGITS, 4, number of BCD decades counted and displayed (1..6)
SATURATE, 1, 1 = hold at all-9s on overflow; 0 = wrap to all-0s

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
move_in  input  1  level from the move-accepted logic; a rising edge counts one move
clear  input  1  synchronous new-game clear (level)
solved  input  1  puzzle-solved level; counting is frozen while high
digits  output  4*NUM_DIGITS  packed BCD count; digit i is digits[4*i+3:4*i], with digit 0 as the least significant
blank  output  NUM_DIGITS  1 = leading zero, so the display should be dark
max_reached  output  1  count equals all-9s (SATURATE=1) or has wrapped at least once (SATURATE=0)
best_digits  output  4*NUM_DIGITS  best (lowest) solved count; only with BEST_SCORE_EN
best_valid  output  1  best_digits holds a real score; only with BEST_SCORE_EN

Behaviour:
- Reset and synchronous reset values:
  - digits = 0.
  - max_reached = 0.
  - move_q = 1, where move_q is the internal copy of move_in registered on the previous edge. The value 1 prevents a false count if move_in is already high when reset releases.
  - best_digits = 0 and best_valid = 0.
- Edge detect:
  - inc = move_in & ~move_q & ~solved.
  - move_q <= move_in on every edge, including while clear or solved is high.
- Latency: when inc is high at edge k, digits shows the incremented value immediately after edge k. This is one cycle after move_in rises.
- BCD arithmetic:
  - Digit 0 increments on inc.
  - Digit i increments when inc is high and every lower digit equals 9.
  - A digit at 9 that increments goes to 0 and carries into the next digit.
  - No digit ever holds a value of 10..15.
- Overflow (all digits 9 and inc high):
  - SATURATE=1: the count holds at all-9s, and max_reached is 1 while the count is all-9s.
  - SATURATE=0: the count wraps to 0, and max_reached is set sticky until clear or reset.
- Priority, highest first: reset, then clear, then solved, then inc.
  - clear zeroes digits and max_reached on that edge. A coincident inc is dropped.
  - clear does not touch the best score.
  - When solved is high, the count holds.
- blank (combinational from the count registers):
  - blank[0] = 0 always.
  - For i>0, blank[i] = 1 when digit i and all higher digits are 0.
  - Example: a count of 0 with 4 digits gives blank = 4'b1110.
- Reset in mid-count has the same effect as a clear, plus move_q = 1.
- No handshake. Outputs are valid every cycle.

Optional Feature:
Macro BEST_SCORE_EN.
- Defined:
  - A rising edge of solved (registered solved_q) compares the current count against best_digits.
  - best_digits is loaded with the current count when best_valid = 0 or current < best. best_valid is then set.
  - The load happens on the edge where solved is 1 and solved_q is 0.
  - A count of 0 is a legal best.
  - SATURATE=0 with max_reached set: the score is not recorded.
- Undefined: best_digits is tied to 0 and best_valid to 0, with no extra registers. The ports remain so the top level is identical in both builds.

Decomposition:
- Shared package:
  - bcd_digit_t, a 4-bit logic type.
  - Constants BCD_MAX = 4'd9, BLANK_SEG = 7'h7F, MAX_DIGITS = 6.
  - A compare function less-than over packed BCD (most significant digit first).
- One sub-module, bcd_decade.
  - Inputs: clk, reset, clr, en_in.
  - Outputs: digit, carry_out (= en_in & digit==9).
  - Instantiated NUM_DIGITS times with a generate loop and a ripple carry chain.

Test Plan:
- Reset with move_in held high, then release -> digits stays 0 and no count until move_in goes low and then high again; afterwards digits = 16'h0001.
- 123 move pulses -> digits = 16'h0123, blank = 4'b1000; move_in held high for 10 cycles still counts once.
- SATURATE=1, preload to 9999 via 9999 pulses, plus one more pulse -> digits stays 16'h9999, max_reached = 1. SATURATE=0: same stimulus -> 16'h0000, max_reached = 1 sticky until clear.
- Count to 0019, then clear and move rising edge on the same cycle -> digits = 16'h0000 and the edge is not counted; the next edge gives 0001.
- solved high at count 0042, with 5 move edges while solved -> digits stays 16'h0042.
- BEST_SCORE_EN:
  - Solve at 0042 -> best = 0042, best_valid = 1.
  - Clear, solve at 0057 -> best unchanged.
  - Clear, solve at 0031 -> best = 0031.
